hilo_regfile: RTL and testbench

- HI/LO architectural register unit for the dynamic pipeline. It is the consumer end of the execute-stage mul/div result interface.
- It tracks mul/div ops issued to execute and not yet written back, and captures their HI/LO results in order.
- It serves MFHI/MFLO reads with same-cycle forwarding, and stalls a read while results are still outstanding.
- It also accepts MTHI/MTLO writes.

---
 rtl/hilo_regfile_if.sv | 36 +++
 rtl/hilo_regfile.sv | 89 ++++++++
 tb/tb_hilo_regfile.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_regfile_if.sv
// rtl/hilo_regfile_if.sv - mul/div writeback, MT write and MF read bundle for the HI/LO unit
interface hilo_regfile_if #(
  parameter int CNT_W = 3
);
  logic             issue_valid;
  logic             issue_ready;
  logic             wb_valid;
  logic [31:0]      wb_hi;
  logic [31:0]      wb_lo;
  logic             mt_valid;
  logic             mt_sel;
  logic [31:0]      mt_data;
  logic             mt_ready;
  logic             rd_valid;
  logic             rd_sel;
  logic             rd_ready;
  logic [31:0]      rd_data;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [CNT_W-1:0] pending;
  logic             err_underflow;

  modport master (
    output issue_valid, wb_valid, wb_hi, wb_lo,
    output mt_valid, mt_sel, mt_data, rd_valid, rd_sel,
    input  issue_ready, mt_ready, rd_ready, rd_data,
    input  hi_q, lo_q, pending, err_underflow
  );

  modport slave (
    input  issue_valid, wb_valid, wb_hi, wb_lo,
    input  mt_valid, mt_sel, mt_data, rd_valid, rd_sel,
    output issue_ready, mt_ready, rd_ready, rd_data,
    output hi_q, lo_q, pending, err_underflow
  );
endinterface

// File: rtl/hilo_regfile.sv
// rtl/hilo_regfile.sv - HI/LO register unit with in-order mul/div writeback, MT writes and forwarded MF reads
module hilo_regfile #(
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  hilo_regfile_if.slave bus
);

  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [CNT_W-1:0] pending_r;
  logic             err_r;

  logic             issue_ready_c;
  logic             issue_acc;
  logic             wb_eff;
  logic             wb_orphan;
  logic             mt_acc;
  logic             rd_ready_c;
  logic [31:0]      rd_data_c;
  logic [CNT_W-1:0] issue_inc;
  logic [CNT_W-1:0] wb_dec;
  logic [CNT_W-1:0] pending_next;

  assign issue_ready_c = (pending_r < CNT_W'(MAX_PENDING));
  assign issue_acc     = bus.issue_valid & issue_ready_c;
  assign wb_eff        = bus.wb_valid & (pending_r != '0);
  // A writeback with nothing outstanding is dropped and only flagged.
  assign wb_orphan     = bus.wb_valid & (pending_r == '0);
  // MT waits for an empty pipe and no younger mul/div entering, keeping program order.
  assign mt_acc        = bus.mt_valid & (pending_r == '0) & ~bus.issue_valid;

  assign issue_inc    = {{(CNT_W-1){1'b0}}, issue_acc};
  assign wb_dec       = {{(CNT_W-1){1'b0}}, wb_eff};
  assign pending_next = pending_r + issue_inc - wb_dec;

  assign rd_ready_c = bus.rd_valid &
                      ((pending_r == '0) |
                       ((pending_r == CNT_W'(1)) & bus.wb_valid & ~bus.issue_valid));

  always_comb begin
    rd_data_c = '0;
    if (rd_ready_c) begin
      if (wb_eff) begin
        rd_data_c = bus.rd_sel ? bus.wb_hi : bus.wb_lo;
      end else if (mt_acc && (bus.mt_sel == bus.rd_sel)) begin
        rd_data_c = bus.mt_data;
      end else begin
        rd_data_c = bus.rd_sel ? hi_r : lo_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_r      <= '0;
      lo_r      <= '0;
      pending_r <= '0;
      err_r     <= 1'b0;
    end else begin
      pending_r <= pending_next;
      if (wb_orphan) begin
        err_r <= 1'b1;
      end
      if (wb_eff) begin
        hi_r <= bus.wb_hi;
        lo_r <= bus.wb_lo;
      end else if (mt_acc) begin
        if (bus.mt_sel) begin
          hi_r <= bus.mt_data;
        end else begin
          lo_r <= bus.mt_data;
        end
      end
    end
  end

  assign bus.issue_ready   = issue_ready_c;
  assign bus.mt_ready      = mt_acc;
  assign bus.rd_ready      = rd_ready_c;
  assign bus.rd_data       = rd_data_c;
  assign bus.hi_q          = hi_r;
  assign bus.lo_q          = lo_r;
  assign bus.pending       = pending_r;
  assign bus.err_underflow = err_r;

endmodule

// File: tb/tb_hilo_regfile.sv
// tb/tb_hilo_regfile.sv - directed scoreboard bench for hilo_regfile
module tb_hilo_regfile;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  hilo_regfile_if #(.CNT_W(3)) bus ();

  hilo_regfile #(.MAX_PENDING(4), .CNT_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic observe(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] exp, input logic [31:0] obs);
    expect_val(tag, exp);
    observe(obs);
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.wb_hi       = '0;
    bus.wb_lo       = '0;
    bus.mt_valid    = 1'b0;
    bus.mt_sel      = 1'b0;
    bus.mt_data     = '0;
    bus.rd_valid    = 1'b0;
    bus.rd_sel      = 1'b0;
  endtask

  task automatic wb(input logic [31:0] h, input logic [31:0] l);
    bus.wb_valid = 1'b1;
    bus.wb_hi    = h;
    bus.wb_lo    = l;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_hi", 32'h0, bus.hi_q);
    chk("rst_lo", 32'h0, bus.lo_q);
    chk("rst_pending", 32'd0, 32'(bus.pending));
    chk("rst_err", 32'd0, 32'(bus.err_underflow));
    chk("rst_issue_ready", 32'd1, 32'(bus.issue_ready));

    // MTHI then MFHI
    @(negedge clk);
    bus.mt_valid = 1'b1; bus.mt_sel = 1'b1; bus.mt_data = 32'hDEADBEEF;
    #1 chk("mthi_ready", 32'd1, 32'(bus.mt_ready));
    @(negedge clk);
    idle();
    chk("mthi_hi_q", 32'hDEADBEEF, bus.hi_q);
    chk("mthi_lo_q", 32'h0, bus.lo_q);
    bus.rd_valid = 1'b1; bus.rd_sel = 1'b1;
    #1;
    chk("mfhi_ready", 32'd1, 32'(bus.rd_ready));
    chk("mfhi_data", 32'hDEADBEEF, bus.rd_data);

    // Fill to MAX_PENDING, fifth issue held
    @(negedge clk);
    idle();
    bus.issue_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("fill_pending", 32'(i), 32'(bus.pending));
    end
    #1 chk("full_issue_ready", 32'd0, 32'(bus.issue_ready));
    @(negedge clk);
    chk("fifth_held_pending", 32'd4, 32'(bus.pending));
    wb(32'h1, 32'h2);
    #1;
    chk("full_wb_same_cycle_pending", 32'd4, 32'(bus.pending));
    chk("full_wb_issue_ready", 32'd0, 32'(bus.issue_ready));
    @(negedge clk);
    chk("full_wb_after_pending", 32'd3, 32'(bus.pending));
    chk("full_wb_hi_q", 32'h1, bus.hi_q);
    bus.issue_valid = 1'b0;
    wb(32'h3, 32'h4);
    @(negedge clk);
    @(negedge clk);
    idle();
    chk("drain_pending", 32'd1, 32'(bus.pending));
    bus.rd_valid = 1'b1; bus.rd_sel = 1'b0;
    #1;
    chk("stall_rd_ready", 32'd0, 32'(bus.rd_ready));
    chk("stall_rd_data", 32'd0, bus.rd_data);

    // Forwarded MFLO in the writeback cycle
    wb(32'h70, 32'h7);
    #1;
    chk("fwd_rd_ready", 32'd1, 32'(bus.rd_ready));
    chk("fwd_rd_data", 32'h7, bus.rd_data);
    @(negedge clk);
    idle();
    chk("fwd_lo_q", 32'h7, bus.lo_q);
    chk("fwd_pending", 32'd0, 32'(bus.pending));

    // pending=2: MFHI and MTLO both stall until drained
    bus.issue_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_sel = 1'b1;
    bus.mt_valid = 1'b1; bus.mt_sel = 1'b0; bus.mt_data = 32'h55;
    #1;
    chk("p2_pending", 32'd2, 32'(bus.pending));
    chk("p2_rd_ready", 32'd0, 32'(bus.rd_ready));
    chk("p2_mt_ready", 32'd0, 32'(bus.mt_ready));
    wb(32'h5, 32'h50);
    #1 chk("p2_wb1_rd_ready", 32'd0, 32'(bus.rd_ready));
    @(negedge clk);
    chk("p2_wb1_hi_q", 32'h5, bus.hi_q);
    wb(32'h9, 32'h90);
    #1;
    chk("p2_wb2_rd_ready", 32'd1, 32'(bus.rd_ready));
    chk("p2_wb2_rd_data", 32'h9, bus.rd_data);
    chk("p2_wb2_mt_ready", 32'd0, 32'(bus.mt_ready));
    @(negedge clk);
    bus.wb_valid = 1'b0;
    #1;
    chk("p2_done_mt_ready", 32'd1, 32'(bus.mt_ready));
    chk("p2_done_rd_data", 32'h9, bus.rd_data);
    @(negedge clk);
    chk("p2_mtlo_lo_q", 32'h55, bus.lo_q);
    chk("p2_mtlo_hi_hold", 32'h9, bus.hi_q);
    bus.rd_sel = 1'b0; bus.mt_data = 32'h66;
    #1 chk("mt_fwd_rd_data", 32'h66, bus.rd_data);
    @(negedge clk);
    idle();

    // Underflow
    wb(32'hAAAA, 32'hBBBB);
    @(negedge clk);
    idle();
    chk("uf_err", 32'd1, 32'(bus.err_underflow));
    chk("uf_hi_hold", 32'h9, bus.hi_q);
    chk("uf_lo_hold", 32'h66, bus.lo_q);
    chk("uf_pending", 32'd0, 32'(bus.pending));
    @(negedge clk);
    chk("uf_sticky", 32'd1, 32'(bus.err_underflow));

    // Reset mid-operation, then a late writeback
    bus.issue_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.issue_valid = 1'b0;
    chk("mid_pending", 32'd3, 32'(bus.pending));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_pending", 32'd0, 32'(bus.pending));
    chk("mid_rst_hi", 32'h0, bus.hi_q);
    chk("mid_rst_lo", 32'h0, bus.lo_q);
    chk("mid_rst_issue_ready", 32'd1, 32'(bus.issue_ready));
    chk("mid_rst_err", 32'd0, 32'(bus.err_underflow));
    wb(32'h1234, 32'h5678);
    @(negedge clk);
    idle();
    chk("late_wb_err", 32'd1, 32'(bus.err_underflow));
    chk("late_wb_hi_drop", 32'h0, bus.hi_q);
    chk("late_wb_pending", 32'd0, 32'(bus.pending));

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
